// File: rtl/ckong_pkg.sv
// Shared types and default memory map for the ckong ROM download slice.
// Imported by the loader FSM and the region decoder.
package ckong_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } dl_state_e;

  typedef enum logic [1:0] {
    RGN_CPU  = 2'd0,
    RGN_GFX1 = 2'd1,
    RGN_GFX2 = 2'd2,
    RGN_PROM = 2'd3
  } region_e;

  // Region boundaries are "first byte past the region".
  localparam logic [16:0] CPU_END_DEF     = 17'h06000;
  localparam logic [16:0] GFX1_END_DEF    = 17'h08000;
  localparam logic [16:0] GFX2_END_DEF    = 17'h09000;
  localparam logic [16:0] IMG_END_DEF     = 17'h09040;
  localparam int          HOLD_CYCLES_DEF = 1024;

endpackage

// File: rtl/rom_region_decode.sv
// Combinational map of a linear download byte address to {region, offset, in_range}.
// Shared by the ROM loader and any other loader that uses the same memory map.
module rom_region_decode
  import ckong_pkg::*;
#(
  parameter logic [16:0] CPU_END  = CPU_END_DEF,
  parameter logic [16:0] GFX1_END = GFX1_END_DEF,
  parameter logic [16:0] GFX2_END = GFX2_END_DEF,
  parameter logic [16:0] IMG_END  = IMG_END_DEF
) (
  input  logic [24:0] addr,
  output region_e     region,
  output logic [16:0] offset,
  output logic        in_range
);

  logic [16:0] a17_s;

  assign a17_s = addr[16:0];

  // Region select and region-relative offset; any set upper bit is out of range
  always_comb begin
    region   = RGN_PROM;
    offset   = a17_s - GFX2_END;
    in_range = (addr[24:17] == 8'd0) && (a17_s < IMG_END);
    if (a17_s < CPU_END) begin
      region = RGN_CPU;
      offset = a17_s;
    end else if (a17_s < GFX1_END) begin
      region = RGN_GFX1;
      offset = a17_s - CPU_END;
    end else if (a17_s < GFX2_END) begin
      region = RGN_GFX2;
      offset = a17_s - GFX1_END;
    end else begin
      region = RGN_PROM;
      offset = a17_s - GFX2_END;
    end
  end

endmodule

// File: rtl/rom_dl_ctrl.sv
// ROM download sequencer: routes the ioctl byte stream into the core's ROM regions,
// checks the stream for gaps/size errors and owns the game core reset.
module rom_dl_ctrl
  import ckong_pkg::*;
#(
  parameter logic [16:0] CPU_END     = CPU_END_DEF,
  parameter logic [16:0] GFX1_END    = GFX1_END_DEF,
  parameter logic [16:0] GFX2_END    = GFX2_END_DEF,
  parameter logic [16:0] IMG_END     = IMG_END_DEF,
  parameter int          HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        user_reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [16:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        cpu_we,
  output logic        gfx1_we,
  output logic        gfx2_we,
  output logic        prom_we,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_err
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  dl_state_e   state_r, state_nxt_s;
  logic        dl_r;
  logic        rise_s, fall_s;
  logic [16:0] cnt_r, cnt_nxt_s;
  logic        err_r, err_nxt_s;
  logic [HW-1:0] hold_r;
  logic        wr_ok_s, strobe_s, image_good_s;
  region_e     region_s;
  logic [16:0] offset_s;
  logic        in_range_s;

  rom_region_decode #(
    .CPU_END  (CPU_END),
    .GFX1_END (GFX1_END),
    .GFX2_END (GFX2_END),
    .IMG_END  (IMG_END)
  ) u_decode (
    .addr     (ioctl_addr),
    .region   (region_s),
    .offset   (offset_s),
    .in_range (in_range_s)
  );

  assign rise_s   = ioctl_download & ~dl_r;
  assign fall_s   = ~ioctl_download & dl_r;
  assign wr_ok_s  = (state_r == LOAD) & ioctl_wr;
  assign strobe_s = wr_ok_s & in_range_s;

  // Expected-address counter and error flag, including a write coincident with the fall
  always_comb begin
    cnt_nxt_s = cnt_r;
    err_nxt_s = err_r;
    if (rise_s) begin
      cnt_nxt_s = 17'd0;
      err_nxt_s = 1'b0;
    end else if (wr_ok_s) begin
      cnt_nxt_s = cnt_r + 17'd1;
      if (!in_range_s || (ioctl_addr != {8'd0, cnt_r})) begin
        err_nxt_s = 1'b1;
      end else begin
        err_nxt_s = err_r;
      end
    end else begin
      cnt_nxt_s = cnt_r;
      err_nxt_s = err_r;
    end
  end

  assign image_good_s = !err_nxt_s && (cnt_nxt_s == IMG_END);

  // Next-state logic; a new download restarts from LOAD in any state
  always_comb begin
    state_nxt_s = state_r;
    if (rise_s) begin
      state_nxt_s = LOAD;
    end else begin
      case (state_r)
        IDLE: state_nxt_s = IDLE;
        LOAD: begin
          if (fall_s) begin
            state_nxt_s = image_good_s ? HOLD : IDLE;
          end else begin
            state_nxt_s = LOAD;
          end
        end
        HOLD: begin
          if (hold_r == HW'(0)) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = HOLD;
          end
        end
        RUN:     state_nxt_s = RUN;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Edge detector, FSM state, integrity state and settle countdown
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_r    <= 1'b0;
      state_r <= IDLE;
      cnt_r   <= 17'd0;
      err_r   <= 1'b0;
      hold_r  <= HW'(0);
    end else begin
      dl_r    <= ioctl_download;
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      err_r   <= err_nxt_s;
      if (state_r == LOAD) begin
        hold_r <= HW'(HOLD_CYCLES - 1);
      end else if ((state_r == HOLD) && (hold_r != HW'(0))) begin
        hold_r <= hold_r - HW'(1);
      end
    end
  end

  // Registered write strobes, download data path and core-facing status
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cpu_we     <= 1'b0;
      gfx1_we    <= 1'b0;
      gfx2_we    <= 1'b0;
      prom_we    <= 1'b0;
      dn_addr    <= 17'd0;
      dn_data    <= 8'd0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      cpu_we  <= strobe_s && (region_s == RGN_CPU);
      gfx1_we <= strobe_s && (region_s == RGN_GFX1);
      gfx2_we <= strobe_s && (region_s == RGN_GFX2);
      prom_we <= strobe_s && (region_s == RGN_PROM);
      if (strobe_s) begin
        dn_addr <= offset_s;
        dn_data <= ioctl_dout;
      end
      core_reset <= (state_nxt_s == RUN) ? user_reset : 1'b1;
      load_done  <= (state_nxt_s == RUN);
      if (rise_s) begin
        load_err <= 1'b0;
      end else if ((state_r == LOAD) && fall_s && !image_good_s) begin
        load_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/rom_dl_ctrl.md
Name: rom_dl_ctrl

Overview:
- Sequences the HPS ROM download stream into the arcade core's ROM/PROM regions and owns the core's game reset.
- Decodes the linear ioctl byte address into per-region write strobes and checks the stream for gaps and size errors.
- Holds the core in reset from power-up until a good image has loaded, plus a settle delay.
- Sits between hps_io (ioctl_*) and the ckong core (dn_addr/dn_data/dn_wr, reset).

Parameters:
- CPU_END, 17'h06000, first byte address past the CPU program ROM region.
- GFX1_END, 17'h08000, first byte address past the tile graphics region.
- GFX2_END, 17'h09000, first byte address past the sprite graphics region.
- IMG_END, 17'h09040, first byte address past the colour PROM region; also the expected total image size.
- HOLD_CYCLES, 1024, clk_sys cycles core_reset stays high after a download ends.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- user_reset  in  1  menu/button reset request, level
- ioctl_download  in  1  download window active
- ioctl_wr  in  1  one-cycle byte strobe
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- dn_addr  out  17  registered region-relative address
- dn_data  out  8  registered data
- cpu_we, gfx1_we, gfx2_we, prom_we  out  1 each  one-cycle region write strobes
- core_reset  out  1  reset to the game core
- load_done  out  1  a good image is resident
- load_err  out  1  the last download was bad (sticky until the next download starts)

Behaviour:
- Reset values: all strobes 0, dn_addr 0, dn_data 0, core_reset 1, load_done 0, load_err 0, FSM in IDLE.
- FSM states:
  - IDLE: core_reset 1. Leaves on a rising edge of ioctl_download to LOAD.
  - LOAD: core_reset 1. On a falling edge of ioctl_download, goes to HOLD if the image is good, otherwise to IDLE.
  - HOLD: core_reset 1. A counter runs from HOLD_CYCLES-1 down to 0. At 0 the FSM goes to RUN.
  - RUN: core_reset = user_reset, registered with 1 cycle of latency. load_done is 1.
- A rising edge of ioctl_download in any state goes to LOAD. In the same cycle it sets load_done 0 and load_err 0, and clears the expected-address counter to 0. core_reset is 1 from the next cycle.
- Write path, LOAD only:
  - ioctl_wr with ioctl_addr < IMG_END produces exactly one strobe, 1 cycle later. dn_data is registered from ioctl_dout.
  - Region decode:
    - addr < CPU_END gives cpu_we with dn_addr = addr.
    - addr < GFX1_END gives gfx1_we with dn_addr = addr-CPU_END.
    - addr < GFX2_END gives gfx2_we with dn_addr = addr-GFX1_END.
    - Otherwise prom_we with dn_addr = addr-GFX2_END.
  - Subtraction is 17-bit, using ioctl_addr[16:0]. Upper address bits [24:17] must be 0 or the byte counts as out of range.
  - Bytes at or beyond IMG_END are not strobed and set the error flag.
  - ioctl_wr outside LOAD is ignored: no strobe, no count.
- Integrity check:
  - The expected-address counter increments by 1 on each accepted write.
  - If ioctl_addr differs from the counter, the error flag is set and the write is still performed.
  - At the falling edge of ioctl_download the image is good only if the error flag is clear and counter == IMG_END.
  - A bad image sets load_err 1 and returns to IDLE, so the core stays in reset.
- Simultaneous events:
  - ioctl_wr in the same cycle as the falling edge of ioctl_download is accepted and counted before the check.
  - A rising edge of ioctl_download during HOLD aborts the countdown.
- Asserting reset mid-download returns to the reset values immediately. A new download is needed before the core runs.

Decomposition:
- Shared package ckong_pkg holds:
  - the FSM state enum (IDLE, LOAD, HOLD, RUN);
  - the default region boundary localparams;
  - the region select enum.
- One natural sub-module: rom_region_decode. It is combinational and maps addr to {region, offset, in_range}, so it can be reused by the hiscore/samples loaders.

Test Plan:
- Power-up, no download: hold for 5000 cycles -> core_reset=1, load_done=0, no strobes.
- Clean load of 0x9040 sequential bytes with data = addr[7:0]:
  - exactly 0x6000 cpu_we, 0x2000 gfx1_we, 0x1000 gfx2_we and 0x40 prom_we strobes;
  - the byte at 0x6000 appears as gfx1_we with dn_addr=0 and dn_data=0x00, 1 cycle after its ioctl_wr;
  - core_reset falls exactly 1024 cycles after ioctl_download falls, and load_done=1.
- Short image of 0x9000 bytes -> load_err=1, FSM back in IDLE, core_reset stays 1.
- Address gap:
  - stimulus: the byte at 0x1234 is skipped;
  - response: the byte at 0x1235 is still strobed with dn_addr=0x1235, and at the end load_err=1 with no HOLD.
- Restart and resets:
  - in RUN, start a new download -> core_reset=1 on the next cycle and load_done=0;
  - assert user_reset in RUN -> core_reset follows 1 cycle later;
  - assert async reset mid-LOAD -> all outputs return to reset values without waiting for a clock edge.
- Edge timing:
  - ioctl_wr at 0x903F coincident with the ioctl_download fall -> accepted as prom_we with dn_addr=0x3F, and the image is good;
  - a write at 0x9040 -> no strobe and load_err=1.
